// File: rtl/time_pkg.sv
// Shared definitions for the time-of-day set controller: mode encodings,
// field widths and limits, key indices, and modular step helpers.
package time_pkg;

    // Operating modes; the display blinks the field named by the SET modes
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } mode_e;

    localparam int HOUR_W     = 5;
    localparam int MINSEC_W   = 6;
    localparam int HOUR_MAX   = 23;
    localparam int MINSEC_MAX = 59;

    // Bit positions inside the active-low key vector
    localparam int KEY_MODE = 0;
    localparam int KEY_INC  = 1;
    localparam int KEY_DEC  = 2;
    localparam int KEY_EXIT = 3;
    localparam int NUM_KEYS = 4;

    // Step up with wrap to zero after max_v; hours use it zero-extended to 6 bits
    function automatic logic [MINSEC_W-1:0] wrap_up(input logic [MINSEC_W-1:0] v,
                                                    input logic [MINSEC_W-1:0] max_v);
        return (v == max_v) ? '0 : v + MINSEC_W'(1);
    endfunction

    // Step down with wrap from zero to max_v
    function automatic logic [MINSEC_W-1:0] wrap_down(input logic [MINSEC_W-1:0] v,
                                                      input logic [MINSEC_W-1:0] max_v);
        return (v == '0) ? max_v : v - MINSEC_W'(1);
    endfunction

endpackage

// File: rtl/key_press_tracker.sv
// Per-key tracker: turns the upstream one-cycle active-low sample pulses into
// a single press event per hold, plus auto-repeat events while the key stays held.
// A key is considered released once HOLD_WIN cycles pass without a pulse.
module key_press_tracker #(
    parameter int HOLD_WIN     = 15_000_000,
    parameter int REPEAT_START = 25,
    parameter int REPEAT_EVERY = 5,
    parameter int CNT_W        = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic pulse_n,
    output logic press,
    output logic repeat_ev
);

    localparam int REP_W = $clog2(REPEAT_START + 1);
    localparam int EVR_W = $clog2(REPEAT_EVERY + 1);

    // rep_cnt counts held samples after the press sample, so the sample numbered
    // REPEAT_START (press sample = 1) is the one where it reaches REPEAT_START-1.
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_START - 1);
    localparam logic [EVR_W-1:0] EVR_LAST = EVR_W'(REPEAT_EVERY);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(HOLD_WIN);

    logic             pulse;
    logic             held;
    logic [CNT_W-1:0] win_cnt;
    logic [REP_W-1:0] rep_cnt;
    logic [EVR_W-1:0] evr_cnt;
    logic [CNT_W-1:0] win_inc;
    logic [REP_W-1:0] rep_inc;
    logic [EVR_W-1:0] evr_inc;
    logic             started;
    logic             start_hit;
    logic             every_hit;

    assign pulse     = ~pulse_n;
    assign press     = pulse && !held;
    assign repeat_ev = pulse && held && (start_hit || every_hit);

    // Counter increments and repeat-point detection for the current sample
    always_comb begin
        win_inc   = win_cnt + CNT_W'(1);
        rep_inc   = rep_cnt + REP_W'(1);
        evr_inc   = evr_cnt + EVR_W'(1);
        started   = (rep_cnt == REP_LAST);
        start_hit = !started && (rep_inc == REP_LAST);
        every_hit = started && (evr_inc == EVR_LAST);
    end

    // Hold state, release window and repeat counters
    always_ff @(posedge clk) begin
        if (rst) begin
            held    <= 1'b0;
            win_cnt <= '0;
            rep_cnt <= '0;
            evr_cnt <= '0;
        end else if (pulse) begin
            win_cnt <= '0;
            if (!held) begin
                held    <= 1'b1;
                rep_cnt <= '0;
                evr_cnt <= '0;
            end else begin
                if (!started) begin
                    rep_cnt <= rep_inc;
                end
                if (start_hit || every_hit) begin
                    evr_cnt <= '0;
                end else if (started) begin
                    evr_cnt <= evr_inc;
                end
            end
        end else if (held) begin
            if (win_inc == WIN_LAST) begin
                held    <= 1'b0;
                win_cnt <= '0;
            end else begin
                win_cnt <= win_inc;
            end
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Digital clock core: hour/min/sec counters advanced by the 1 Hz strobe, and a
// set-mode state machine driven by MODE/INC/DEC/EXIT key events for editing them.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int HOLD_WIN     = 15_000_000,
    parameter int REPEAT_START = 25,
    parameter int REPEAT_EVERY = 5,
    parameter int CNT_W        = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    input  logic                tick_1hz,
    output logic [HOUR_W-1:0]   hour,
    output logic [MINSEC_W-1:0] min,
    output logic [MINSEC_W-1:0] sec,
    output logic [1:0]          mode
);

    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] rep_ev;
    logic                unused_rep;

    logic ev_mode;
    logic ev_exit;
    logic ev_inc;
    logic ev_dec;
    logic exit_taken;
    logic mode_taken;
    logic adj_en;
    logic adj_up;
    logic run_tick;

    mode_e state;
    mode_e state_next;

    logic [HOUR_W-1:0]   hour_nxt;
    logic [MINSEC_W-1:0] min_nxt;
    logic [MINSEC_W-1:0] sec_nxt;
    logic [MINSEC_W-1:0] hour_up;
    logic [MINSEC_W-1:0] hour_down;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_press_tracker #(
            .HOLD_WIN    (HOLD_WIN),
            .REPEAT_START(REPEAT_START),
            .REPEAT_EVERY(REPEAT_EVERY),
            .CNT_W       (CNT_W)
        ) u_tracker (
            .clk      (clk),
            .rst      (rst),
            .pulse_n  (key_in[k]),
            .press    (press[k]),
            .repeat_ev(rep_ev[k])
        );
    end

    // MODE and EXIT never auto-repeat, so their repeat outputs go nowhere
    assign unused_rep = rep_ev[KEY_MODE] | rep_ev[KEY_EXIT];

    assign ev_mode = press[KEY_MODE];
    assign ev_exit = press[KEY_EXIT];
    assign ev_inc  = press[KEY_INC] | rep_ev[KEY_INC];
    assign ev_dec  = press[KEY_DEC] | rep_ev[KEY_DEC];

    assign mode = state;

    // Mode state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next mode: EXIT (only meaningful in a SET mode) beats MODE stepping
    always_comb begin
        exit_taken = ev_exit && (state != RUN);
        mode_taken = ev_mode && !exit_taken;
        state_next = state;
        if (exit_taken) begin
            state_next = RUN;
        end else if (mode_taken) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                default:  state_next = RUN;
            endcase
        end
    end

    // Mode-dependent controls: clock runs only in RUN, edits only when INC/DEC win
    always_comb begin
        run_tick = (state == RUN) && tick_1hz;
        adj_en   = (state != RUN) && !exit_taken && !mode_taken && (ev_inc ^ ev_dec);
        adj_up   = ev_inc;
    end

    // Next time value: ripple carry on the 1 Hz tick, or a single-field edit
    always_comb begin
        hour_nxt  = hour;
        min_nxt   = min;
        sec_nxt   = sec;
        hour_up   = wrap_up({1'b0, hour}, MINSEC_W'(HOUR_MAX));
        hour_down = wrap_down({1'b0, hour}, MINSEC_W'(HOUR_MAX));
        if (run_tick) begin
            sec_nxt = wrap_up(sec, MINSEC_W'(MINSEC_MAX));
            if (sec == MINSEC_W'(MINSEC_MAX)) begin
                min_nxt = wrap_up(min, MINSEC_W'(MINSEC_MAX));
                if (min == MINSEC_W'(MINSEC_MAX)) begin
                    hour_nxt = hour_up[HOUR_W-1:0];
                end
            end
        end else if (adj_en) begin
            case (state)
                SET_HOUR: hour_nxt = adj_up ? hour_up[HOUR_W-1:0] : hour_down[HOUR_W-1:0];
                SET_MIN:  min_nxt  = adj_up ? wrap_up(min, MINSEC_W'(MINSEC_MAX))
                                            : wrap_down(min, MINSEC_W'(MINSEC_MAX));
                SET_SEC:  sec_nxt  = '0;
                default:  ;
            endcase
        end
    end

    // Time registers feeding the display
    always_ff @(posedge clk) begin
        if (rst) begin
            hour <= '0;
            min  <= '0;
            sec  <= '0;
        end else begin
            hour <= hour_nxt;
            min  <= min_nxt;
            sec  <= sec_nxt;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with short hold/repeat parameters and
// upstream-style key pulses every 10 cycles while a key is held.
module tb_time_set_ctrl;

    localparam logic [3:0] K_NONE = 4'b1111;
    localparam logic [3:0] K_MODE = 4'b1110;
    localparam logic [3:0] K_INC  = 4'b1101;
    localparam logic [3:0] K_DEC  = 4'b1011;
    localparam logic [3:0] K_EXIT = 4'b0111;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic       tick_1hz;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .HOLD_WIN    (15),
        .REPEAT_START(4),
        .REPEAT_EVERY(2),
        .CNT_W       (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_in  (key_in),
        .tick_1hz(tick_1hz),
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .mode    (mode)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        key_in   = K_NONE;
        tick_1hz = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic pulse(input logic [3:0] k);
        key_in = k;
        cycle();
        key_in = K_NONE;
    endtask

    task automatic release_keys();
        idle(20);
    endtask

    task automatic tap(input logic [3:0] k);
        pulse(k);
        release_keys();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1hz = 1'b1;
            cycle();
            tick_1hz = 1'b0;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        key_in   = K_NONE;
        tick_1hz = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
        checks++; if (hour !== 5'd0) begin failures++; $display("[TB] FAIL reset_hour: got %0d want 0", hour); end
        checks++; if (min !== 6'd0) begin failures++; $display("[TB] FAIL reset_min: got %0d want 0", min); end
        checks++; if (sec !== 6'd0) begin failures++; $display("[TB] FAIL reset_sec: got %0d want 0", sec); end
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL reset_mode: got %0d want 0", mode); end
        ticks(3);
        checks++; if ({hour, min, sec} !== {5'd0, 6'd0, 6'd3}) begin failures++; $display("[TB] FAIL three_ticks: got %0d:%0d:%0d want 0:0:3", hour, min, sec); end
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL three_ticks_mode: got %0d want 0", mode); end
    endtask

    task automatic test_rollover();
        ticks(56);
        checks++; if (sec !== 6'd59) begin failures++; $display("[TB] FAIL run_to_59: got %0d want 59", sec); end
        pulse(K_MODE);
        checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL roll_enter_set: got %0d want 1", mode); end
        release_keys();
        pulse(K_DEC);
        checks++; if (hour !== 5'd23) begin failures++; $display("[TB] FAIL roll_hour_dec: got %0d want 23", hour); end
        release_keys();
        pulse(K_MODE);
        checks++; if (mode !== 2'd2) begin failures++; $display("[TB] FAIL roll_to_setmin: got %0d want 2", mode); end
        release_keys();
        pulse(K_DEC);
        checks++; if (min !== 6'd59) begin failures++; $display("[TB] FAIL roll_min_dec: got %0d want 59", min); end
        release_keys();
        pulse(K_EXIT);
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL roll_exit: got %0d want 0", mode); end
        checks++; if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin failures++; $display("[TB] FAIL roll_kept: got %0d:%0d:%0d want 23:59:59", hour, min, sec); end
        release_keys();
        ticks(1);
        checks++; if ({hour, min, sec} !== {5'd0, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL midnight: got %0d:%0d:%0d want 0:0:0", hour, min, sec); end
    endtask

    task automatic test_hold_mode();
        pulse(K_MODE);
        checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL hold_first: got %0d want 1", mode); end
        for (int i = 1; i <= 3; i++) begin
            idle(9);
            pulse(K_MODE);
            checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL hold_pulse%0d: got %0d want 1", i + 1, mode); end
        end
        release_keys();
        pulse(K_MODE);
        checks++; if (mode !== 2'd2) begin failures++; $display("[TB] FAIL hold_repress: got %0d want 2", mode); end
        release_keys();
        pulse(K_EXIT);
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL hold_exit: got %0d want 0", mode); end
        release_keys();
        pulse(K_MODE);
        checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL hold_reenter: got %0d want 1", mode); end
        release_keys();
    endtask

    task automatic test_hour_adjust();
        logic [4:0] exp_h [8];
        exp_h = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd2, 5'd2, 5'd3};
        pulse(K_DEC);
        checks++; if (hour !== 5'd23) begin failures++; $display("[TB] FAIL hour_dec_wrap: got %0d want 23", hour); end
        release_keys();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle(9);
            pulse(K_INC);
            checks++; if (hour !== exp_h[i]) begin failures++; $display("[TB] FAIL hour_repeat_p%0d: got %0d want %0d", i + 1, hour, exp_h[i]); end
        end
        release_keys();
    endtask

    task automatic test_min_adjust();
        tap(K_INC);
        pulse(K_INC);
        checks++; if (hour !== 5'd5) begin failures++; $display("[TB] FAIL hour_to_5: got %0d want 5", hour); end
        release_keys();
        pulse(K_MODE);
        checks++; if (mode !== 2'd2) begin failures++; $display("[TB] FAIL to_setmin: got %0d want 2", mode); end
        release_keys();
        pulse(K_DEC);
        checks++; if (min !== 6'd59) begin failures++; $display("[TB] FAIL min_dec_wrap: got %0d want 59", min); end
        release_keys();
        pulse(K_INC);
        checks++; if ({hour, min} !== {5'd5, 6'd0}) begin failures++; $display("[TB] FAIL min_inc_nocarry: got %0d:%0d want 5:0", hour, min); end
        release_keys();
        ticks(10);
        checks++; if ({hour, min, sec} !== {5'd5, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL set_frozen: got %0d:%0d:%0d want 5:0:0", hour, min, sec); end
        checks++; if (mode !== 2'd2) begin failures++; $display("[TB] FAIL set_frozen_mode: got %0d want 2", mode); end
    endtask

    task automatic test_simultaneous();
        pulse(4'b1001);
        checks++; if ({hour, min, sec} !== {5'd5, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL inc_dec_cancel: got %0d:%0d:%0d want 5:0:0", hour, min, sec); end
        release_keys();
        tap(K_MODE);
        tap(K_MODE);
        pulse(K_MODE);
        checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL cycle_to_sethour: got %0d want 1", mode); end
        release_keys();
        pulse(4'b1100);
        checks++; if (mode !== 2'd2) begin failures++; $display("[TB] FAIL mode_inc_mode: got %0d want 2", mode); end
        checks++; if (hour !== 5'd5) begin failures++; $display("[TB] FAIL mode_inc_hour: got %0d want 5", hour); end
        release_keys();
        pulse(4'b0110);
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL exit_beats_mode: got %0d want 0", mode); end
        release_keys();
        key_in   = K_MODE;
        tick_1hz = 1'b1;
        cycle();
        key_in   = K_NONE;
        tick_1hz = 1'b0;
        checks++; if (sec !== 6'd1) begin failures++; $display("[TB] FAIL tick_with_mode_sec: got %0d want 1", sec); end
        checks++; if (mode !== 2'd1) begin failures++; $display("[TB] FAIL tick_with_mode_mode: got %0d want 1", mode); end
        release_keys();
        pulse(K_EXIT);
        checks++; if (mode !== 2'd0) begin failures++; $display("[TB] FAIL exit_to_run: got %0d want 0", mode); end
        release_keys();
        pulse(K_EXIT);
        checks++; if ({mode, hour, min, sec} !== {2'd0, 5'd5, 6'd0, 6'd1}) begin failures++; $display("[TB] FAIL exit_in_run: got mode %0d %0d:%0d:%0d want mode 0 5:0:1", mode, hour, min, sec); end
        release_keys();
    endtask

    task automatic test_reset_mid_edit();
        ticks(55);
        tap(K_MODE);
        repeat (7) tap(K_INC);
        tap(K_MODE);
        repeat (34) tap(K_INC);
        checks++; if ({mode, hour, min, sec} !== {2'd2, 5'd12, 6'd34, 6'd56}) begin failures++; $display("[TB] FAIL edit_setup: got mode %0d %0d:%0d:%0d want mode 2 12:34:56", mode, hour, min, sec); end
        pulse(K_INC);
        checks++; if (min !== 6'd35) begin failures++; $display("[TB] FAIL edit_press: got %0d want 35", min); end
        idle(9);
        pulse(K_INC);
        checks++; if (min !== 6'd35) begin failures++; $display("[TB] FAIL edit_held: got %0d want 35", min); end
        idle(4);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if ({mode, hour, min, sec} !== {2'd0, 5'd0, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL mid_edit_reset: got mode %0d %0d:%0d:%0d want mode 0 0:0:0", mode, hour, min, sec); end
        idle(4);
        pulse(K_INC);
        checks++; if ({mode, hour, min, sec} !== {2'd0, 5'd0, 6'd0, 6'd0}) begin failures++; $display("[TB] FAIL post_reset_inc: got mode %0d %0d:%0d:%0d want mode 0 0:0:0", mode, hour, min, sec); end
        release_keys();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        key_in   = K_NONE;
        tick_1hz = 1'b0;
        test_reset();
        test_rollover();
        test_hold_mode();
        test_hour_adjust();
        test_min_adjust();
        test_simultaneous();
        test_reset_mid_edit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
